// File: rtl/note_tone_player.sv
// Single-voice square-wave note player: accepts one note event, looks up its
// half-period through an external ROM, and toggles tone for the requested duration.
module note_tone_player #(
    parameter int unsigned TICK_DIV = 50,
    parameter int unsigned DUR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [4:0]       note_idx,
    input  logic [DUR_W-1:0] note_dur,
    input  logic             note_rest,
    output logic [4:0]       rom_i,
    input  logic [7:0]       rom_d,
    output logic             tone,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } state_t;

    state_t           state;
    logic [DUR_W-1:0] dur_cnt;
    logic             rest_r;
    logic [7:0]       period_r;
    logic [7:0]       phase;
    logic [PW-1:0]    presc;

    assign note_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_i    <= '0;
            dur_cnt  <= '0;
            rest_r   <= 1'b0;
            period_r <= '0;
            phase    <= '0;
            presc    <= '0;
            tone     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (note_valid) begin
                        rom_i   <= note_idx;
                        dur_cnt <= note_dur;
                        rest_r  <= note_rest;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    period_r <= rom_d;
                    // a zero period cannot produce a tone, so it plays as silence
                    rest_r   <= rest_r | (rom_d == '0);
                    phase    <= '0;
                    presc    <= '0;
                    tone     <= 1'b0;
                    if (dur_cnt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (phase == period_r - 8'd1) begin
                        phase <= '0;
                        if (!rest_r)
                            tone <= ~tone;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                    // end-of-note assignments come last so they override any toggle
                    if (presc == PRE_LAST) begin
                        presc   <= '0;
                        dur_cnt <= dur_cnt - 1'b1;
                        if (dur_cnt == DUR_W'(1)) begin
                            tone  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_tone_player.sv
// Scoreboard bench for note_tone_player: a negedge monitor turns each note into
// an observed record, compared against records computed from the note parameters.
module tb_note_tone_player;

    localparam int unsigned TICK_DIV = 50;
    localparam int unsigned DUR_W    = 8;

    typedef struct packed {
        logic [4:0] idx;
        int         busy_len;
        int         toggles;
        int         first_rise;
        int         last_tog;
        logic       tone_start;
        logic       tone_end;
        logic       ready_at_done;
        int         done_after;
    } rec_t;

    logic             clk;
    logic             rst;
    logic             note_valid;
    logic             note_ready;
    logic [4:0]       note_idx;
    logic [DUR_W-1:0] note_dur;
    logic             note_rest;
    logic [4:0]       rom_i;
    logic [7:0]       rom_d;
    logic             tone;
    logic             busy;
    logic             done;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    int   last_gap = 0;

    note_tone_player #(.TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
        .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
        .note_idx(note_idx), .note_dur(note_dur), .note_rest(note_rest),
        .rom_i(rom_i), .rom_d(rom_d), .tone(tone), .busy(busy), .done(done)
    );

    function automatic logic [7:0] rom_val(input logic [4:0] i);
        case (i)
            5'd31:   return 8'd21;
            5'd12:   return 8'd64;
            5'd5:    return 8'd96;
            5'd0:    return 8'd30;
            5'd3:    return 8'd0;
            default: return 8'(20 + int'(i));
        endcase
    endfunction

    assign rom_d = rom_val(rom_i);

    function automatic rec_t model(input logic [4:0] idx, input int dur, input bit rest);
        rec_t m;
        int p;
        int play;
        p    = int'(rom_val(idx));
        play = int'(TICK_DIV) * dur;
        m.idx           = idx;
        m.busy_len      = 1 + play;
        m.toggles       = 0;
        m.first_rise    = -1;
        m.last_tog      = -1;
        m.tone_start    = 1'b0;
        m.tone_end      = 1'b0;
        m.ready_at_done = 1'b1;
        m.done_after    = 1;
        if (!rest && p != 0 && play > 0) begin
            m.toggles = (play - 1) / p;
            if (m.toggles > 0) begin
                m.first_rise = p;
                m.last_tog   = p * m.toggles;
            end
        end
        return m;
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf("idx=%0d busy=%0d tog=%0d rise=%0d last=%0d ts=%b te=%b rdy=%b da=%0d",
                         r.idx, r.busy_len, r.toggles, r.first_rise, r.last_tog,
                         r.tone_start, r.tone_end, r.ready_at_done, r.done_after);
    endfunction

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Monitor: samples mid-cycle, builds one record per note, pushes it on DONE.
    initial begin
        rec_t cur;
        bit   prev_busy;
        logic prev_tone;
        int   start;
        int   last_busy;
        int   last_done;
        cur = '0; prev_busy = 0; prev_tone = 1'b0;
        start = 0; last_busy = 0; last_done = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_busy = 0;
                prev_tone = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    cur            = '0;
                    cur.idx        = rom_i;
                    cur.first_rise = -1;
                    cur.last_tog   = -1;
                    cur.tone_start = tone;
                    start          = cyc;
                    last_gap       = cyc - last_done;
                end
                if (busy) begin
                    cur.busy_len++;
                    last_busy = cyc;
                    if (prev_busy && tone !== prev_tone) begin
                        cur.toggles++;
                        if (tone && cur.first_rise < 0)
                            cur.first_rise = cyc - start - 1;
                        cur.last_tog = cyc - start - 1;
                    end
                end
                if (done) begin
                    done_cnt++;
                    cur.tone_end      = tone;
                    cur.ready_at_done = note_ready;
                    cur.done_after    = cyc - last_busy;
                    last_done         = cyc;
                    obs_q.push_back(cur);
                end
                prev_busy = busy;
                prev_tone = tone;
            end
        end
    end

    task automatic drive_note(input logic [4:0] idx, input int dur, input bit rest);
        int k;
        k = 0;
        @(negedge clk);
        while (!note_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!note_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_wait: note_ready=%b, required 1", note_ready);
        end
        note_idx   = idx;
        note_dur   = DUR_W'(dur);
        note_rest  = rest;
        note_valid = 1'b1;
        exp_q.push_back(model(idx, dur, rest));
        @(posedge clk);
        #1 note_valid = 1'b0;
    endtask

    task automatic collect(output rec_t o, output rec_t e, output bit ok);
        int k;
        k = 0;
        while (obs_q.size() == 0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        ok = (obs_q.size() > 0);
        o  = ok ? obs_q.pop_front() : '0;
        e  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; note_valid = 1'b0; note_idx = '0; note_dur = '0; note_rest = 1'b0;
        #2 rst = 1'b1;
        #2;
        n_checks++;
        if ({tone, busy, done, rom_i} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: tone=%b busy=%b done=%b rom_i=%0d, required all 0", tone, busy, done, rom_i);
        end
        n_checks++;
        if (note_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: note_ready=%b, required 0", note_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (note_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: note_ready=%b, required 1", note_ready);
        end
    endtask

    task automatic test_tone_timing();
        rec_t o, e;
        bit   ok;
        drive_note(5'd31, 1, 1'b0);
        collect(o, e, ok);
        n_checks++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL tone_timing: got %s (seen=%0b), required %s", fmt(o), ok, fmt(e));
        end
    endtask

    task automatic test_long_note();
        rec_t o, e;
        bit   ok;
        drive_note(5'd12, 3, 1'b0);
        collect(o, e, ok);
        n_checks++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL long_note: got %s (seen=%0b), required %s", fmt(o), ok, fmt(e));
        end
    endtask

    task automatic test_rest_and_zero();
        rec_t o, e;
        bit   ok;
        drive_note(5'd31, 2, 1'b1);
        collect(o, e, ok);
        n_checks++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL rest_note: got %s (seen=%0b), required %s", fmt(o), ok, fmt(e));
        end
        drive_note(5'd12, 0, 1'b0);
        collect(o, e, ok);
        n_checks++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL zero_dur: got %s (seen=%0b), required %s", fmt(o), ok, fmt(e));
        end
        drive_note(5'd3, 1, 1'b0);
        collect(o, e, ok);
        n_checks++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL zero_period: got %s (seen=%0b), required %s", fmt(o), ok, fmt(e));
        end
    endtask

    task automatic test_back_to_back();
        rec_t o, e;
        bit   ok;
        int   k;
        @(negedge clk);
        note_idx = 5'd0; note_dur = DUR_W'(1); note_rest = 1'b0; note_valid = 1'b1;
        exp_q.push_back(model(5'd0, 1, 1'b0));
        @(posedge clk);
        #1;
        note_idx = 5'd5; note_dur = DUR_W'(2);
        exp_q.push_back(model(5'd5, 2, 1'b0));
        k = 0;
        @(negedge clk);
        while (!done && k < 500) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 note_valid = 1'b0;
        collect(o, e, ok);
        n_checks++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL b2b_first: got %s (seen=%0b), required %s", fmt(o), ok, fmt(e));
        end
        collect(o, e, ok);
        n_checks++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL b2b_second: got %s (seen=%0b), required %s", fmt(o), ok, fmt(e));
        end
        n_checks++;
        if (last_gap !== 1) begin
            n_fail++;
            $display("FAIL b2b_gap: cycles from DONE to next BUSY=%0d, required 1", last_gap);
        end
    endtask

    task automatic test_busy_protect();
        rec_t o, e;
        bit   ok;
        int   base;
        drive_note(5'd31, 2, 1'b0);
        repeat (60) @(negedge clk);
        note_idx = 5'd7; note_dur = DUR_W'(9); note_valid = 1'b1;
        @(posedge clk);
        #1 note_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rom_i !== 5'd31) begin
            n_fail++;
            $display("FAIL busy_rom_i: rom_i=%0d, required 31", rom_i);
        end
        collect(o, e, ok);
        n_checks++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL busy_protect: got %s (seen=%0b), required %s", fmt(o), ok, fmt(e));
        end
        base = done_cnt;
        repeat (30) @(negedge clk);
        n_checks++;
        if (done_cnt !== base || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_extra_done: done pulses=%0d, required %0d", done_cnt, base);
        end
    endtask

    task automatic test_reset_mid_note();
        rec_t o, e;
        bit   ok;
        int   k;
        int   base;
        drive_note(5'd31, 2, 1'b0);
        k = 0;
        while (tone !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (tone !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_tone_high: tone=%b, required 1 before reset", tone);
        end
        #3 rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        n_checks++;
        if ({tone, busy, done, rom_i} !== 8'd0 || note_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: tone=%b busy=%b done=%b rom_i=%0d ready=%b, required all 0",
                     tone, busy, done, rom_i, note_ready);
        end
        base = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (note_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ready: note_ready=%b, required 1", note_ready);
        end
        repeat (150) @(negedge clk);
        n_checks++;
        if (done_cnt !== base || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reset_done: done pulses=%0d, required %0d", done_cnt, base);
        end
        drive_note(5'd5, 1, 1'b0);
        collect(o, e, ok);
        n_checks++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL after_reset_note: got %s (seen=%0b), required %s", fmt(o), ok, fmt(e));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tone_timing();
        test_long_note();
        test_rest_and_zero();
        test_back_to_back();
        test_busy_protect();
        test_reset_mid_note();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_tone_player.md
# note_tone_player

Plays one note at a time as a square wave: accepts note events (index, duration, rest flag) through a valid/ready handshake and drives the 5-bit index to the note-period lookup. It then toggles TONE every ROM_D clocks for the requested duration, and pulses DONE when the note ends. It sits between the sequencer/loop memory and the audio output pin, consuming the period values the note ROM produces.

## Interface
- TICK_DIV, 50: clocks per duration unit (1 ms at the 50 kHz CLK).
- DUR_W, 8: width of NOTE_DUR.
- CLK  in  1  50 kHz system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- NOTE_VALID  in  1  note event offered.
- NOTE_READY  out  1  block can accept; high only in IDLE and RST low.
- NOTE_IDX  in  5  note index, sampled on accept.
- NOTE_DUR  in  DUR_W  duration in TICK_DIV-clock units, sampled on accept.
- NOTE_REST  in  1  silent note (time passes, TONE held 0), sampled on accept.
- ROM_I  out  5  registered index to the combinational note-period ROM.
- ROM_D  in  8  period in clocks per TONE half-cycle, valid same cycle as ROM_I.
- TONE  out  1  square-wave output.
- BUSY  out  1  high in LOAD and PLAY.
- DONE  out  1  one-cycle pulse at note end.

## Operation
- States: IDLE, LOAD, PLAY.
- IDLE:
  - NOTE_READY=1.
  - On NOTE_VALID&NOTE_READY, capture IDX→ROM_I, DUR→dur_cnt, REST→rest_r, then go to LOAD.
  - With NOTE_VALID low, stay in IDLE.
- LOAD (exactly 1 cycle):
  - Latch ROM_D→period_r and clear the phase and prescale counters.
  - If dur_cnt==0, go to IDLE and pulse DONE; otherwise go to PLAY.
  - ROM_D==0 is treated as a rest.
- PLAY:
  - Phase counter counts 0..period_r-1. On reaching period_r-1 it wraps to 0 and TONE toggles, unless rest_r is set, in which case TONE stays 0.
  - Prescaler counts 0..TICK_DIV-1. On wrap, dur_cnt decrements.
  - When the prescaler wraps with dur_cnt==1, go to IDLE, force TONE=0 and pulse DONE.
- NOTE_VALID, NOTE_IDX, NOTE_DUR and NOTE_REST are ignored outside IDLE; a new note cannot interrupt a playing note.
- ROM_I holds the last accepted index until the next accept.
- Counter widths:
  - Phase counter: 8 bits.
  - Prescaler: ceil(log2(TICK_DIV)) bits.
  - dur_cnt: DUR_W bits, never wraps below 0.
- Reset (asynchronous, any state): state=IDLE, TONE=0, BUSY=0, DONE=0, NOTE_READY=0 while RST is high, ROM_I=0, and all counters cleared. A note in progress is abandoned with no DONE pulse.

## Timing
- Accept at edge t0 → LOAD during cycle t0..t1 (BUSY=1, NOTE_READY=0, ROM_I valid) → PLAY starts at t1 with TONE=0.
- First TONE rise occurs at edge t1+P, where P=period_r; later toggles occur every P edges after that. TONE always starts a note at phase 0, low.
- PLAY lasts exactly DUR×TICK_DIV cycles. Total BUSY = 1 + DUR×TICK_DIV cycles (1 cycle if DUR=0).
- DONE is high for the single cycle after BUSY falls, coincident with NOTE_READY=1. A note offered in that same cycle is accepted, giving back-to-back notes with a 1-cycle IDLE gap.
- TONE is registered; there are no combinational paths from inputs to TONE or DONE. NOTE_READY is decoded from the state register.

## Test plan
- Reset mid-note: RST pulsed during PLAY with TONE=1 → TONE, BUSY, DONE and ROM_I read 0 asynchronously, NOTE_READY=0. After RST falls, NOTE_READY=1 and no DONE pulse occurs.
- Tone timing, IDX=31 (ROM_D=21), DUR=1, TICK_DIV=50:
  - ROM_I=31 during LOAD.
  - TONE rises at PLAY cycle 21, falls at 42, and returns to 0 at end.
  - BUSY lasts 51 cycles, DONE pulses once.
- Long note, IDX=12 (ROM_D=64), DUR=3 → TONE period 128 cycles; toggles at PLAY cycles 64 and 128; BUSY lasts 151 cycles.
- Rest and zero duration:
  - REST=1, DUR=2 → TONE stays 0 for 100 cycles, BUSY high, DONE pulses.
  - DUR=0 → BUSY for 1 cycle (LOAD), DONE next cycle, TONE never toggles.
- Back-to-back: NOTE_VALID held high with IDX=0 then IDX=5 → second note accepted in the DONE cycle. ROM_I changes to 5, TONE restarts low, and the second rise occurs 96 cycles into its PLAY.
- Busy protection: NOTE_VALID pulsed with IDX=7 during PLAY → ignored. ROM_I, TONE phase and end time are unchanged, and no extra DONE pulse occurs.
